// File: rtl/oni16_pkg.sv
`default_nettype none
// oni16_pkg: shared types and defaults for the Oni16 instruction fetch stage.
// Rev 1.0
package oni16_pkg;

  localparam int ADDR_W = 16;
  localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;

  typedef enum logic [0:0] {
    REQ_LO = 1'b0,
    REQ_HI = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [15:0]       instr;
    logic [ADDR_W-1:0] pc;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/oni16_fetch_fifo.sv
`default_nettype none
// oni16_fetch_fifo: synchronous FIFO of fetch entries; flush beats push and pop.
// Rev 1.0
module oni16_fetch_fifo
  import oni16_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  fetch_entry_t                 push_data,
  input  logic                         pop,
  input  logic                         flush,
  output fetch_entry_t                 head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  fetch_entry_t  slots [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign head    = slots[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      slots[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      if (do_push && !do_pop) begin
        count <= count + CW'(1);
      end else if (do_pop && !do_push) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/oni16_fetch.sv
`default_nettype none
// oni16_fetch: byte-wide program fetch, little-endian 16-bit assembly, instruction FIFO.
// Rev 1.0
module oni16_fetch #(
  parameter int                ADDR_W   = oni16_pkg::ADDR_W,
  parameter int                DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = oni16_pkg::RESET_PC
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [7:0]        mem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  output logic [15:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready,
  output logic              fetch_err
);

  import oni16_pkg::*;

  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = CW + 1;

  fetch_state_t      state;
  fetch_state_t      state_next;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] pend_addr;
  logic [ADDR_W-1:0] asm_pc;
  logic [7:0]        asm_lo;
  logic              pend_valid;
  logic              pend_hi;
  logic              pend_drop;
  logic              asm_pending;

  logic [CW-1:0]     fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  fetch_entry_t      fifo_head;
  fetch_entry_t      push_entry;
  logic              fifo_push;
  logic              fifo_pop;

  logic [OW-1:0]     occupancy;
  logic              credit_ok;
  logic              grant;
  logic              rsp_live;
  logic              rsp_lo;
  logic              rsp_hi;

  // A lo fetch is only started when the instruction it begins has a FIFO slot
  // reserved; a pop in the same cycle is deliberately not counted.
  assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, asm_pending};
  assign credit_ok = !fifo_full && (occupancy < OW'(DEPTH));

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= REQ_LO;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    mem_req    = 1'b0;
    mem_addr   = fetch_pc;
    case (state)
      REQ_LO: begin
        mem_req = credit_ok;
        if (credit_ok && mem_gnt) begin
          state_next = REQ_HI;
        end
      end
      REQ_HI: begin
        mem_req  = 1'b1;
        mem_addr = fetch_pc + ADDR_W'(1);
        if (mem_gnt) begin
          state_next = REQ_LO;
        end
      end
      default: state_next = REQ_LO;
    endcase
    if (reset) begin
      mem_req = 1'b0;
    end
    if (redirect) begin
      state_next = REQ_LO;
    end
  end

  assign grant      = mem_req && mem_gnt;
  assign rsp_live   = mem_rvalid && pend_valid && !pend_drop && !redirect;
  assign rsp_lo     = rsp_live && !pend_hi;
  assign rsp_hi     = rsp_live && pend_hi;
  assign fifo_push  = rsp_hi;
  assign fifo_pop   = instr_valid && instr_ready;
  assign push_entry = {mem_rdata, asm_lo, asm_pc};

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      pend_valid  <= 1'b0;
      pend_hi     <= 1'b0;
      pend_drop   <= 1'b1;
      pend_addr   <= '0;
      asm_pending <= 1'b0;
      asm_lo      <= '0;
      asm_pc      <= '0;
      fetch_err   <= 1'b0;
    end else begin
      pend_valid <= grant;
      pend_hi    <= (state == REQ_HI);
      pend_drop  <= redirect;
      pend_addr  <= mem_addr;
      if (mem_rvalid && !pend_valid && !pend_drop) begin
        fetch_err <= 1'b1;
      end
      if (redirect) begin
        fetch_pc    <= redirect_pc;
        asm_pending <= 1'b0;
      end else begin
        if ((state == REQ_HI) && mem_gnt) begin
          fetch_pc <= fetch_pc + ADDR_W'(2);
        end
        if (rsp_lo) begin
          asm_lo      <= mem_rdata;
          asm_pc      <= pend_addr;
          asm_pending <= 1'b1;
        end else if (rsp_hi) begin
          asm_pending <= 1'b0;
        end
      end
    end
  end

  oni16_fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .flush     (redirect),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign instr_valid = !fifo_empty;
  assign instr       = fifo_empty ? '0 : fifo_head.instr;
  assign instr_pc    = fifo_empty ? '0 : fifo_head.pc;

endmodule
`default_nettype wire

// File: tb/tb_oni16_fetch.sv
`default_nettype none
// tb_oni16_fetch: randomized and directed stimulus against a program-order reference stream.
module tb_oni16_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [7:0]  mem_rdata = 8'h00;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        instr_valid;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_ready = 1'b0;
  logic        fetch_err;

  always #5 clk = ~clk;

  oni16_fetch #(
    .ADDR_W   (16),
    .DEPTH    (2),
    .RESET_PC (16'h0000)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_gnt     (mem_gnt),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready),
    .fetch_err   (fetch_err)
  );

  typedef struct {
    logic [15:0] instr;
    logic [15:0] pc;
  } exp_t;

  logic [7:0]  mem [0:65535];
  exp_t        sb [$];
  int          n_vec = 0;
  int          n_err = 0;
  logic        resp_due = 1'b0;
  logic [15:0] resp_addr = 16'h0000;
  logic        exp_err = 1'b0;
  logic        prev_rst = 1'b1;
  logic        prev_stall = 1'b0;
  logic [15:0] prev_addr = 16'h0000;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Program order from a start PC: each instruction is {mem[pc+1], mem[pc]}, pc steps by 2 mod 2^16.
  task automatic load_expect(input logic [15:0] start);
    logic [15:0] a;
    exp_t        e;
    a = start;
    sb.delete();
    for (int i = 0; i < 64; i++) begin
      e.instr = {mem[a + 16'd1], mem[a]};
      e.pc    = a;
      sb.push_back(e);
      a = a + 16'd2;
    end
  endtask

  task automatic step(input logic rst, input logic g, input logic r, input logic rd,
                      input logic [15:0] rpc, input logic spur);
    @(posedge clk);
    #1;
    reset       = rst;
    mem_rvalid  = resp_due | spur;
    mem_rdata   = resp_due ? mem[resp_addr] : 8'($urandom);
    mem_gnt     = g;
    instr_ready = r;
    redirect    = rd;
    redirect_pc = rpc;
    if (!rst && (prev_rst || rd)) load_expect(rd ? rpc : 16'h0000);
    if (rst) exp_err = 1'b0;
    @(negedge clk);
    if (!rst) begin
      check("fetch_err", fetch_err, exp_err);
      if (prev_stall) begin
        check("stall_req", mem_req, 1);
        check("stall_addr", mem_addr, prev_addr);
      end
    end
    prev_stall = !rst && mem_req && !mem_gnt && !rd;
    prev_addr  = mem_addr;
    resp_due   = mem_req && mem_gnt;
    resp_addr  = mem_addr;
    if (spur) exp_err = 1'b1;
    prev_rst = rst;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset && !redirect && instr_valid && instr_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_underflow: got pc %h, expected no instruction", instr_pc);
      end else begin
        e = sb.pop_front();
        check("instr", instr, e.instr);
        check("instr_pc", instr_pc, e.pc);
      end
    end
  end

  initial begin : stim
    logic [5:0]  pat;
    logic        g, r, rd;
    logic [15:0] rpc;
    int          seg;

    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h34; mem[1] = 8'h12; mem[2] = 8'h78; mem[3] = 8'h56;

    // reset values, then first-instruction timing
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 1, 0, 16'h0000, 0);
      if (i > 0) begin
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_addr", mem_addr, 16'h0000);
        check("rst_valid", instr_valid, 0);
        check("rst_instr", instr, 0);
        check("rst_instr_pc", instr_pc, 0);
        check("rst_fetch_err", fetch_err, 0);
      end
    end
    pat = 6'b101000;
    for (int c = 0; c < 6; c++) begin
      step(0, 1, 1, 0, 16'h0000, 0);
      if (c == 0) check("post_rst_req", mem_req, 1);
      check("valid_timing", instr_valid, pat[c]);
    end

    // core stalled: FIFO fills, fetch stops, spurious response flags an error
    step(0, 1, 0, 1, 16'h0200, 0);
    repeat (14) step(0, 1, 0, 0, 16'h0000, 0);
    check("full_valid", instr_valid, 1);
    check("full_head_pc", instr_pc, 16'h0200);
    check("full_no_req", mem_req, 0);
    step(0, 1, 0, 0, 16'h0000, 1);
    repeat (3) step(0, 1, 0, 0, 16'h0000, 0);
    check("err_head_pc", instr_pc, 16'h0200);
    step(0, 1, 1, 0, 16'h0000, 0);
    check("drain0_valid", instr_valid, 1);
    check("drain0_no_req", mem_req, 0);
    step(0, 1, 1, 0, 16'h0000, 0);
    check("drain1_valid", instr_valid, 1);
    check("drain1_req", mem_req, 1);
    step(0, 1, 1, 0, 16'h0000, 0);
    check("drain2_empty", instr_valid, 0);
    repeat (6) step(0, 1, 1, 0, 16'h0000, 0);

    // redirect coinciding with a lo response and a pop
    step(0, 1, 1, 1, 16'h0400, 0);
    repeat (3) step(0, 1, 1, 0, 16'h0000, 0);
    step(0, 1, 1, 1, 16'h0101, 0);
    check("redir_pop_valid", instr_valid, 1);
    step(0, 1, 1, 0, 16'h0000, 0);
    check("flush_empty", instr_valid, 0);
    repeat (10) step(0, 1, 1, 0, 16'h0000, 0);

    // grant withheld during the hi request
    step(0, 1, 1, 1, 16'h0300, 0);
    step(0, 1, 1, 0, 16'h0000, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 0, 16'h0000, 0);
      check("hold_req", mem_req, 1);
      check("hold_addr", mem_addr, 16'h0301);
    end
    repeat (8) step(0, 1, 1, 0, 16'h0000, 0);

    // address wrap at the top of memory
    step(0, 1, 1, 1, 16'hFFFE, 0);
    repeat (8) step(0, 1, 1, 0, 16'h0000, 0);
    step(0, 1, 1, 1, 16'hFFFF, 0);
    step(0, 1, 1, 0, 16'h0000, 0);
    check("wrap_lo_addr", mem_addr, 16'hFFFF);
    step(0, 1, 1, 0, 16'h0000, 0);
    check("wrap_hi_addr", mem_addr, 16'h0000);
    repeat (8) step(0, 1, 1, 0, 16'h0000, 0);

    // only reset clears the sticky error
    repeat (2) step(1, 1, 1, 0, 16'h0000, 0);
    step(0, 1, 1, 0, 16'h0000, 0);

    // randomized traffic
    seg = 0;
    for (int i = 0; i < 1500; i++) begin
      g   = ($urandom_range(3) != 0);
      r   = ($urandom_range(3) != 0);
      rd  = (seg >= 100) || ($urandom_range(49) == 0);
      rpc = ($urandom_range(7) == 0) ? (16'hFFF8 | 16'($urandom_range(7))) : 16'($urandom);
      step(0, g, r, rd, rpc, 0);
      seg = rd ? 0 : seg + 1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/oni16_fetch.md
# oni16_fetch

Instruction fetch stage directly upstream of the Oni16 core. Reads byte-wide program memory, assembles little-endian 16-bit instructions, and buffers them in a small FIFO. The core consumes them through a valid/ready handshake. A redirect input (branch, call, return, interrupt) flushes the buffer and restarts fetch at a new PC.

## Interface
- `ADDR_W`, 16, program-memory address width and PC width.
- `DEPTH`, 2, instruction FIFO entries; must be ≥1.
- `RESET_PC`, 16'h0000, fetch address after reset.

- `clk`  in  1  sole clock; all logic is rising-edge.
- `reset`  in  1  synchronous, active-high.
- `mem_req`  out  1  read request for `mem_addr`.
- `mem_addr`  out  ADDR_W  byte address of the request.
- `mem_gnt`  in  1  request accepted this cycle.
- `mem_rvalid`  in  1  read data valid; arrives exactly 1 cycle after an accepted request.
- `mem_rdata`  in  8  read data byte.
- `redirect`  in  1  flush and restart fetch.
- `redirect_pc`  in  ADDR_W  new fetch address; sampled when `redirect`=1.
- `instr_valid`  out  1  FIFO head is valid.
- `instr`  out  16  FIFO head instruction, {hi byte, lo byte}.
- `instr_pc`  out  ADDR_W  address of the instruction's low byte.
- `instr_ready`  in  1  core accepts the head; pop when valid&&ready.
- `fetch_err`  out  1  sticky: `mem_rvalid` seen with no response pending.

## Operation
- FSM `fetch_state_t`: REQ_LO, REQ_HI.
- **REQ_LO:**
  - `mem_req`=1 only if `fifo_count` + `asm_pending` < DEPTH. Occupancy is the registered value; a same-cycle pop is not credited.
  - `mem_addr`=`fetch_pc`.
  - On gnt: go to REQ_HI.
- **REQ_HI:**
  - `mem_req`=1, `mem_addr`=`fetch_pc`+1, mod 2^ADDR_W.
  - On gnt: `fetch_pc`+=2 (wraps) and go to REQ_LO.
- **Response tracking:**
  - Registered `pend_valid`, `pend_hi`, `pend_drop` describe the response due next cycle.
  - Lo response: latch byte into `asm_lo`; latch its address into `asm_pc`; set `asm_pending`.
  - Hi response: push {`mem_rdata`, `asm_lo`} with `asm_pc` into the FIFO; clear `asm_pending`.
- **Redirect (priority over everything except reset):**
  - FIFO emptied; a same-cycle pop is ignored.
  - `asm_pending` cleared.
  - Any response arriving this cycle or next is dropped via `pend_drop`.
  - `fetch_pc`←`redirect_pc`; state←REQ_LO.
- **Odd PC:** legal. Low byte at PC, high byte at PC+1. At PC=FFFF the high byte is read from 0000.
- **Reset:**
  - `fetch_pc`=RESET_PC, state=REQ_LO, FIFO empty, `asm_pending`=0.
  - `pend_valid`=0, `pend_drop`=1, so a stray response in the first cycle after reset is dropped without error.
- **Reset values:**
  - `mem_req` is combinational. It is 1 in the first post-reset cycle; it is 0 while `reset` is held.
  - All other outputs: `mem_addr`=RESET_PC, `instr_valid`=0, `instr`=0, `instr_pc`=0, `fetch_err`=0.
- **`fetch_err`:** set by an unexpected `mem_rvalid` (no response pending and no drop pending); cleared only by reset.
- **FIFO full:**
  - Fetch stalls in REQ_LO; an assembling instruction always has a reserved slot.
  - No instruction is dropped or duplicated.

## Timing
- Zero-wait memory (gnt=1), ready=1, redirect at t:
  - t+1: request lo at A.
  - t+2: lo data; request hi at A+1.
  - t+3: hi data, FIFO write; request lo at A+2.
  - t+4: `instr_valid`=1.
- Sustained throughput: 1 instruction per 2 cycles.
- `instr_valid` drops to 0 the cycle after redirect.
- FIFO push-to-head latency is 1 cycle.
- Simultaneous push and pop when full is not possible; the credit rule prevents it.
- `mem_gnt`=0 holds the state, `mem_req` and `mem_addr` stable until granted.

## Structure
- Package `oni16_pkg`:
  - `ADDR_W` default.
  - `RESET_PC` default.
  - `fetch_state_t` enum.
  - `fetch_entry_t` struct {instr[15:0], pc[ADDR_W-1:0]}.
- Sub-module `oni16_fetch_fifo`: synchronous FIFO of `fetch_entry_t`.
  - Parameter DEPTH.
  - Ports: push, pop, flush, count, full, empty.
  - Flush wins over push and pop.

## Test plan
- Reset with RESET_PC=0000; memory bytes 0000..0003 = 34,12,78,56; ready=1 -> `instr`=1234 at pc 0000 at cycle 4, then 5678 at pc 0002 at cycle 6.
- `instr_ready`=0 with DEPTH=2 -> exactly 2 entries buffered; `mem_req` stays 0 in REQ_LO; releasing ready delivers 1234 then 5678 with no loss.
- Redirect to 0x0101 issued in the same cycle as a lo response and a pop -> the response is dropped, the FIFO is empty next cycle, and the next instruction is {mem[0102],mem[0101]} with pc 0101.
- Fetch at FFFE then FFFF (via redirect) -> addresses FFFE, FFFF, 0000; the instruction at FFFF has its high byte from 0000.
- `mem_gnt` held 0 for 3 cycles during REQ_HI -> `mem_addr` stays PC+1; the instruction is correct after grant.
- Spurious `mem_rvalid` while idle-full -> `fetch_err`=1 and stays 1 until reset; the FIFO contents are unchanged.
